// File: rtl/popcount_pkg.sv
// Shared definitions for the popcount_stream block.
//   pop_mode_e           : per-word counting mode (ones / zeros)
//   clog2p1()            : width needed to hold a count of 0..n inclusive
//   POPCOUNT_CHECK_DIV() : elaboration check that the word splits evenly into leaves
`ifndef POPCOUNT_PKG_SV
`define POPCOUNT_PKG_SV

`define POPCOUNT_CHECK_DIV(width, leaf_w) \
  if ((leaf_w) < 1 || (width) < 1 || ((width) % (leaf_w)) != 0) begin : g_div_check \
    $error("popcount: WIDTH must be >= 1 and a multiple of LEAF_W"); \
  end

package popcount_pkg;

  typedef enum logic {
    POP_ONES  = 1'b0,
    POP_ZEROS = 1'b1
  } pop_mode_e;

  // A count of 0..n needs $clog2(n)+1 bits (n itself must be representable).
  function automatic int unsigned clog2p1(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

endpackage

`endif

// File: rtl/popcount_stream_if.sv
// Streaming bus for popcount_stream.
//   master : upstream word source / statistics consumer (drives *_i, reads *_o)
//   slave  : the popcount_stream block
// Signals: data_val_i, data_i, mode_i, last_i (word in); data_o, data_val_o (per-word count);
//          acc_o, acc_val_o, acc_ovf_o (burst total).
interface popcount_stream_if
  import popcount_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ACC_W = 16
);
  localparam int unsigned CntW = clog2p1(WIDTH);

  logic             data_val_i;
  logic [WIDTH-1:0] data_i;
  pop_mode_e        mode_i;
  logic             last_i;
  logic [CntW-1:0]  data_o;
  logic             data_val_o;
  logic [ACC_W-1:0] acc_o;
  logic             acc_val_o;
  logic             acc_ovf_o;

  modport master (
    output data_val_i, data_i, mode_i, last_i,
    input  data_o, data_val_o, acc_o, acc_val_o, acc_ovf_o
  );

  modport slave (
    input  data_val_i, data_i, mode_i, last_i,
    output data_o, data_val_o, acc_o, acc_val_o, acc_ovf_o
  );
endinterface

// File: rtl/popcount_leaf.sv
// Combinational population count of one LEAF_W-bit slice.
//   bits_i : slice to count
//   cnt_o  : number of ones in bits_i (0..LEAF_W)
module popcount_leaf
  import popcount_pkg::*;
#(
  parameter int unsigned LEAF_W = 8,
  localparam int unsigned CntW = clog2p1(LEAF_W)
) (
  input  logic [LEAF_W-1:0] bits_i,
  output logic [CntW-1:0]   cnt_o
);

  always_comb begin
    cnt_o = '0;
    for (int unsigned i = 0; i < LEAF_W; i++) begin
      cnt_o = cnt_o + CntW'(bits_i[i]);
    end
  end

endmodule

// File: rtl/popcount_stream.sv
// Pipelined population counter for a stream of words with per-burst saturating totals.
//   clk_i    : clock, all state on rising edge
//   arst_n_i : asynchronous active-low reset (release synchronised externally)
//   bus      : popcount_stream_if slave port
//              in : data_val_i, data_i, mode_i (ones/zeros), last_i (end of burst)
//              out: data_o/data_val_o (count, 3 register stages after the word)
//                   acc_o/acc_ovf_o/acc_val_o (burst total, one cycle after the last count)
module popcount_stream
  import popcount_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned LEAF_W = 8,
  parameter int unsigned ACC_W  = 16
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  popcount_stream_if.slave bus
);

  localparam int unsigned NumLeaves = WIDTH / LEAF_W;
  localparam int unsigned LeafCntW  = clog2p1(LEAF_W);
  localparam int unsigned CntW      = clog2p1(WIDTH);
  localparam int unsigned AccSumW   = ACC_W + 1;

  `POPCOUNT_CHECK_DIV(WIDTH, LEAF_W)

  if (ACC_W < CntW) begin : g_acc_check
    $error("popcount_stream: ACC_W must be >= $clog2(WIDTH)+1");
  end

  // S0: input register
  logic             s0_val_q;
  logic [WIDTH-1:0] s0_data_q;
  pop_mode_e        s0_mode_q;
  logic             s0_last_q;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      s0_val_q  <= 1'b0;
      s0_data_q <= '0;
      s0_mode_q <= POP_ONES;
      s0_last_q <= 1'b0;
    end else begin
      s0_val_q <= bus.data_val_i;
      if (bus.data_val_i) begin
        s0_data_q <= bus.data_i;
        s0_mode_q <= bus.mode_i;
        s0_last_q <= bus.last_i;
      end
    end
  end

  // Counting zeros is counting ones of the inverted word.
  logic [WIDTH-1:0] leaf_in;
  assign leaf_in = (s0_mode_q == POP_ZEROS) ? ~s0_data_q : s0_data_q;

  // S1: registered leaf counts
  logic [LeafCntW-1:0] leaf_cnt   [NumLeaves];
  logic [LeafCntW-1:0] leaf_cnt_q [NumLeaves];
  logic                s1_val_q;
  logic                s1_last_q;

  for (genvar g = 0; g < NumLeaves; g++) begin : g_leaf
    popcount_leaf #(
      .LEAF_W (LEAF_W)
    ) u_leaf (
      .bits_i (leaf_in[g*LEAF_W +: LEAF_W]),
      .cnt_o  (leaf_cnt[g])
    );
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      s1_val_q  <= 1'b0;
      s1_last_q <= 1'b0;
      for (int unsigned i = 0; i < NumLeaves; i++) begin
        leaf_cnt_q[i] <= '0;
      end
    end else begin
      s1_val_q <= s0_val_q;
      if (s0_val_q) begin
        s1_last_q  <= s0_last_q;
        leaf_cnt_q <= leaf_cnt;
      end
    end
  end

  // Leaf sum, full width so an all-ones word yields exactly WIDTH.
  logic [CntW-1:0] tree_sum;

  always_comb begin
    tree_sum = '0;
    for (int unsigned i = 0; i < NumLeaves; i++) begin
      tree_sum = tree_sum + CntW'(leaf_cnt_q[i]);
    end
  end

  // S2: per-word count output
  logic [CntW-1:0] data_q;
  logic            data_val_q;
  logic            s2_last_q;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      data_q     <= '0;
      data_val_q <= 1'b0;
      s2_last_q  <= 1'b0;
    end else begin
      data_val_q <= s1_val_q;
      if (s1_val_q) begin
        data_q    <= tree_sum;
        s2_last_q <= s1_last_q;
      end
    end
  end

  // Burst accumulator
  logic [ACC_W-1:0] run_q;
  logic             ovf_q;
  logic             first_q;
  logic [ACC_W-1:0] acc_q;
  logic             acc_val_q;
  logic             acc_ovf_q;

  logic [ACC_W-1:0]   acc_base;
  logic [AccSumW-1:0] acc_sum;
  logic               acc_ovf_now;
  logic [ACC_W-1:0]   acc_sat;

  // One extra bit is enough: the addend is at most WIDTH < 2^ACC_W.
  always_comb begin
    acc_base    = first_q ? '0 : run_q;
    acc_sum     = AccSumW'(acc_base) + AccSumW'(data_q);
    acc_ovf_now = acc_sum[ACC_W];
    acc_sat     = acc_ovf_now ? '1 : acc_sum[ACC_W-1:0];
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      run_q     <= '0;
      ovf_q     <= 1'b0;
      first_q   <= 1'b1;
      acc_q     <= '0;
      acc_val_q <= 1'b0;
      acc_ovf_q <= 1'b0;
    end else begin
      acc_val_q <= 1'b0;
      if (data_val_q) begin
        run_q   <= acc_sat;
        first_q <= s2_last_q;
        if (s2_last_q) begin
          acc_q     <= acc_sat;
          acc_ovf_q <= ovf_q | acc_ovf_now;
          acc_val_q <= 1'b1;
          ovf_q     <= 1'b0;
        end else begin
          ovf_q <= ovf_q | acc_ovf_now;
        end
      end
    end
  end

  assign bus.data_o     = data_q;
  assign bus.data_val_o = data_val_q;
  assign bus.acc_o      = acc_q;
  assign bus.acc_val_o  = acc_val_q;
  assign bus.acc_ovf_o  = acc_ovf_q;

endmodule

// File: tb/tb_popcount_stream.sv
// Bench for popcount_stream: two instances (ACC_W=16 and ACC_W=6) share one stimulus stream.
// A cycle monitor compares both against a burst-level model; table vectors and hand-written
// sequences add fixed expectations for the documented corner cases.
module tb_popcount_stream;
  import popcount_pkg::*;

  localparam int unsigned W  = 32;
  localparam longint Max16   = 65535;
  localparam longint Max6    = 63;

  logic clk = 1'b0;
  logic arst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  popcount_stream_if #(.WIDTH(W), .ACC_W(16)) bus16 ();
  popcount_stream_if #(.WIDTH(W), .ACC_W(6))  bus6 ();

  popcount_stream #(.WIDTH(W), .LEAF_W(8), .ACC_W(16)) dut16 (
    .clk_i    (clk),
    .arst_n_i (arst_n),
    .bus      (bus16)
  );

  popcount_stream #(.WIDTH(W), .LEAF_W(8), .ACC_W(6)) dut6 (
    .clk_i    (clk),
    .arst_n_i (arst_n),
    .bus      (bus6)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Applies one input beat to both instances; it is captured at the following rising edge.
  task automatic step(input logic v, input logic [W-1:0] d, input logic m, input logic l);
    @(negedge clk);
    bus16.data_val_i = v;
    bus16.data_i     = d;
    bus16.mode_i     = pop_mode_e'(m);
    bus16.last_i     = l;
    bus6.data_val_i  = v;
    bus6.data_i      = d;
    bus6.mode_i      = pop_mode_e'(m);
    bus6.last_i      = l;
  endtask

  // Invalid beat carrying junk data and last=1, which must be ignored.
  task automatic idle();
    step(1'b0, $urandom(), 1'($urandom_range(0, 1)), 1'b1);
  endtask

  // ---------------- reference model / monitor ----------------
  typedef struct {
    int cnt;
    bit last;
    int due;
  } beat_t;

  beat_t mq[$];
  bit    acc_pend = 1'b0;

  initial begin : monitor
    int          ek;
    longint      held_cnt, burst_sum, acc_total, dv_exp;
    longint      e_acc16, e_ovf16, e_acc6, e_ovf6;
    bit          acc_now, dv_now;
    int          acc_due;
    bit          sv, sm, sl;
    logic [W-1:0] sd;
    beat_t       b;
    ek = 0; held_cnt = 0; burst_sum = 0; acc_total = 0; acc_due = 0;
    e_acc16 = 0; e_ovf16 = 0; e_acc6 = 0; e_ovf6 = 0;
    forever begin
      @(posedge clk);
      ek++;
      sv = bus16.data_val_i;
      sd = bus16.data_i;
      sm = bus16.mode_i;
      sl = bus16.last_i;
      #1;
      if (!arst_n) begin
        mq.delete();
        acc_pend = 1'b0;
        held_cnt = 0; burst_sum = 0;
        e_acc16 = 0; e_ovf16 = 0; e_acc6 = 0; e_ovf6 = 0;
        check("mon rst data_o", bus16.data_o, 0);
        check("mon rst data_val_o", bus16.data_val_o, 0);
        check("mon rst acc_o", bus16.acc_o, 0);
        check("mon rst acc_val_o", bus16.acc_val_o, 0);
        check("mon rst acc_ovf_o", bus6.acc_ovf_o, 0);
      end else begin
        acc_now = acc_pend && (acc_due == ek);
        if (acc_now) begin
          acc_pend = 1'b0;
          e_acc16  = (acc_total > Max16) ? Max16 : acc_total;
          e_ovf16  = (acc_total > Max16) ? 1 : 0;
          e_acc6   = (acc_total > Max6) ? Max6 : acc_total;
          e_ovf6   = (acc_total > Max6) ? 1 : 0;
        end
        check("mon acc_val16", bus16.acc_val_o, longint'(acc_now));
        check("mon acc_val6", bus6.acc_val_o, longint'(acc_now));
        check("mon acc16", bus16.acc_o, e_acc16);
        check("mon ovf16", bus16.acc_ovf_o, e_ovf16);
        check("mon acc6", bus6.acc_o, e_acc6);
        check("mon ovf6", bus6.acc_ovf_o, e_ovf6);

        dv_now = (mq.size() > 0) && (mq[0].due == ek);
        if (dv_now) begin
          b = mq.pop_front();
          held_cnt  = b.cnt;
          burst_sum += b.cnt;
          if (b.last) begin
            acc_pend  = 1'b1;
            acc_due   = ek + 1;
            acc_total = burst_sum;
            burst_sum = 0;
          end
        end
        dv_exp = dv_now ? 1 : 0;
        check("mon data_val16", bus16.data_val_o, dv_exp);
        check("mon data_val6", bus6.data_val_o, dv_exp);
        check("mon data16", bus16.data_o, held_cnt);
        check("mon data6", bus6.data_o, held_cnt);

        if (sv) begin
          mq.push_back('{cnt: sm ? int'(W) - $countones(sd) : $countones(sd), last: sl,
                         due: ek + 2});
        end
      end
    end
  end

  // ---------------- table vectors ----------------
  typedef struct {
    logic [W-1:0] data;
    logic         mode;
    int           cnt;
  } vec_t;

  vec_t tbl[10];

  initial begin : main
    bus16.data_val_i = 1'b0; bus16.data_i = '0; bus16.mode_i = POP_ONES; bus16.last_i = 1'b0;
    bus6.data_val_i  = 1'b0; bus6.data_i  = '0; bus6.mode_i  = POP_ONES; bus6.last_i  = 1'b0;
    arst_n = 1'b1;
    #1 arst_n = 1'b0;

    tbl[0] = '{32'hFFFF_FFFF, 1'b0, 32};
    tbl[1] = '{32'h0000_0001, 1'b1, 31};
    tbl[2] = '{32'h0000_0000, 1'b0, 0};
    tbl[3] = '{32'hF0F0_F0F0, 1'b0, 16};
    tbl[4] = '{32'h0000_0000, 1'b1, 32};
    tbl[5] = '{32'h8000_0001, 1'b0, 2};
    tbl[6] = '{32'h0000_FFFF, 1'b1, 16};
    tbl[7] = '{32'h1234_5678, 1'b0, 13};
    tbl[8] = '{32'hA5A5_A5A5, 1'b1, 16};
    tbl[9] = '{32'h7FFF_FFFF, 1'b0, 31};

    repeat (2) @(negedge clk);
    check("reset data_o", bus16.data_o, 0);
    check("reset data_val_o", bus16.data_val_o, 0);
    check("reset acc_o", bus16.acc_o, 0);
    check("reset acc_val_o", bus16.acc_val_o, 0);
    check("reset acc_ovf_o", bus16.acc_ovf_o, 0);
    @(negedge clk);
    arst_n = 1'b1;

    // Each vector as a single-word burst: acc_o equals the word count.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, tbl[i].data, tbl[i].mode, 1'b1);
      idle(); idle(); idle();
      check("tbl data_val_o", bus16.data_val_o, 1);
      check("tbl data_o", bus16.data_o, tbl[i].cnt);
      idle();
      check("tbl acc_val_o", bus16.acc_val_o, 1);
      check("tbl acc16", bus16.acc_o, tbl[i].cnt);
      check("tbl acc6", bus6.acc_o, tbl[i].cnt);
      check("tbl ovf6", bus6.acc_ovf_o, 0);
    end

    // Three-beat burst followed immediately by a one-beat burst.
    step(1'b1, 32'hF0F0_F0F0, 1'b0, 1'b0);
    step(1'b1, 32'h0000_0001, 1'b0, 1'b0);
    step(1'b1, 32'h0000_0003, 1'b0, 1'b1);
    step(1'b1, 32'h0000_00FF, 1'b0, 1'b1);
    check("b2b data 16", bus16.data_o, 16);
    idle();
    check("b2b data 1", bus16.data_o, 1);
    idle();
    check("b2b data 2", bus16.data_o, 2);
    idle();
    check("b2b data 8", bus16.data_o, 8);
    check("b2b acc 19", bus16.acc_o, 19);
    check("b2b acc_val 19", bus16.acc_val_o, 1);
    idle();
    check("b2b acc 8", bus16.acc_o, 8);
    check("b2b acc6 8", bus6.acc_o, 8);
    check("b2b acc_val 8", bus16.acc_val_o, 1);
    idle();
    check("acc hold", bus16.acc_o, 8);
    check("acc_val pulse", bus16.acc_val_o, 0);

    // Saturation in the 6-bit instance, then a clean burst.
    repeat (3) step(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    step(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);
    step(1'b1, 32'h0000_0001, 1'b0, 1'b1);
    idle(); idle(); idle();
    check("sat acc6", bus6.acc_o, 63);
    check("sat ovf6", bus6.acc_ovf_o, 1);
    check("sat acc16", bus16.acc_o, 128);
    check("sat ovf16", bus16.acc_ovf_o, 0);
    idle();
    check("post-sat acc6", bus6.acc_o, 1);
    check("post-sat ovf6", bus6.acc_ovf_o, 0);

    // Gapped valids inside one burst.
    step(1'b1, 32'h0000_001F, 1'b0, 1'b0);
    idle();
    step(1'b1, 32'h0000_0003, 1'b1, 1'b0);
    idle();
    check("gap data 5", bus16.data_o, 5);
    step(1'b1, 32'h0000_0007, 1'b0, 1'b1);
    check("gap hold 5", bus16.data_o, 5);
    check("gap val 0", bus16.data_val_o, 0);
    idle();
    check("gap data 30", bus16.data_o, 30);
    idle();
    check("gap hold 30", bus16.data_o, 30);
    idle();
    check("gap data 3", bus16.data_o, 3);
    idle();
    check("gap acc 38", bus16.acc_o, 38);
    check("gap acc_val", bus16.acc_val_o, 1);

    // Asynchronous reset mid-burst after part of the sum has been accumulated.
    step(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    step(1'b1, 32'h0000_00FF, 1'b0, 1'b0);
    step(1'b1, 32'h0000_000F, 1'b0, 1'b0);
    step(1'b1, 32'h0000_0001, 1'b0, 1'b0);
    #2 arst_n = 1'b0;
    #1;
    check("async rst data_o", bus16.data_o, 0);
    check("async rst data_val_o", bus16.data_val_o, 0);
    check("async rst acc_o", bus16.acc_o, 0);
    check("async rst acc6", bus6.acc_o, 0);
    check("async rst acc_val_o", bus16.acc_val_o, 0);
    idle(); idle();
    arst_n = 1'b1;
    step(1'b1, 32'h0000_0003, 1'b0, 1'b1);
    idle(); idle(); idle();
    check("post-rst data", bus16.data_o, 2);
    idle();
    check("post-rst acc", bus16.acc_o, 2);
    check("post-rst acc6", bus6.acc_o, 2);
    check("post-rst acc_val", bus16.acc_val_o, 1);

    // Randomised stream, checked by the monitor.
    for (int i = 0; i < 600; i++) begin
      logic [W-1:0] d;
      int           sel;
      sel = $urandom_range(0, 5);
      d   = $urandom();
      if (sel == 0) d = '1;
      if (sel == 1) d = '0;
      step(1'($urandom_range(0, 9) < 7), d, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) == 0));
    end
    repeat (8) step(1'b0, '0, 1'b0, 1'b0);
    check("drain", longint'(mq.size()) + longint'(acc_pend), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
